// File: rtl/ppi_bus_arbiter.sv
// ppi_bus_arbiter: shares the 8255 PPI CPU-side bus between the Z80 decoder (cpu) and an
// auxiliary master (aux). Arbitrates in IDLE, latches the winning request, then runs a
// SETUP / STROBE / HOLD / DONE sequence on csn/rdn/wrn and returns a one-cycle ack.
module ppi_bus_arbiter #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter bit          CPU_PRIORITY  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       aux_req,
  input  logic       aux_we,
  input  logic [1:0] aux_addr,
  input  logic [7:0] aux_wdata,
  output logic       aux_ack,
  output logic [7:0] aux_rdata,
  output logic [1:0] ppi_addr,
  output logic [7:0] ppi_din,
  input  logic [7:0] ppi_dout,
  output logic       ppi_csn,
  output logic       ppi_rdn,
  output logic       ppi_wrn,
  output logic       busy
);

  localparam logic [3:0] StrobeLoad = 4'(STROBE_CYCLES);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;  // 1 = aux owns the current transaction
  logic       last_q, last_d;    // 1 = aux received the most recent grant
  logic       we_q, we_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] aux_rdata_q, aux_rdata_d;
  logic       grant_aux;

  // State and datapath registers; reset leaves last_q = aux so cpu wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 8'd0;
      cpu_rdata_q <= 8'd0;
      aux_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  // Next-state logic: arbitration, request latching, strobe timing and read capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;

    // On a tie, round-robin picks whoever did not win last time.
    if (cpu_req && aux_req) begin
      grant_aux = CPU_PRIORITY ? 1'b0 : ~last_q;
    end else begin
      grant_aux = aux_req;
    end

    unique case (state_q)
      StIdle: begin
        if (cpu_req || aux_req) begin
          state_d = StSetup;
          owner_d = grant_aux;
          last_d  = grant_aux;
          we_d    = grant_aux ? aux_we    : cpu_we;
          addr_d  = grant_aux ? aux_addr  : cpu_addr;
          wdata_d = grant_aux ? aux_wdata : cpu_wdata;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = StrobeLoad;
      end
      StStrobe: begin
        if (cnt_q <= 4'd1) begin
          state_d = StHold;
          if (!we_q) begin
            if (owner_q) aux_rdata_d = ppi_dout;
            else         cpu_rdata_d = ppi_dout;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state so an asynchronous reset clears them at once.
  always_comb begin
    ppi_csn   = ~(state_q == StSetup || state_q == StStrobe || state_q == StHold);
    ppi_rdn   = ~(state_q == StStrobe && !we_q);
    ppi_wrn   = ~(state_q == StStrobe && we_q);
    cpu_ack   = (state_q == StDone) && !owner_q;
    aux_ack   = (state_q == StDone) && owner_q;
    busy      = (state_q != StIdle);
    ppi_addr  = addr_q;
    ppi_din   = wdata_q;
    cpu_rdata = cpu_rdata_q;
    aux_rdata = aux_rdata_q;
  end

endmodule

// File: tb/tb_ppi_bus_arbiter.sv
// Directed bench for ppi_bus_arbiter. dut0: STROBE_CYCLES=2, round-robin.
// dut1: STROBE_CYCLES=1, cpu priority (cpu-only stimulus plus aux contention).
module tb_ppi_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [1:0] cpu_addr = 2'd0;
  logic [7:0] cpu_wdata = 8'd0;
  logic       aux_req = 1'b0, aux_we = 1'b0;
  logic [1:0] aux_addr = 2'd0;
  logic [7:0] aux_wdata = 8'd0;
  logic [7:0] ppi_dout = 8'd0;
  logic       cpu_ack, aux_ack, ppi_csn, ppi_rdn, ppi_wrn, busy;
  logic [7:0] cpu_rdata, aux_rdata, ppi_din;
  logic [1:0] ppi_addr;

  logic       b_cpu_req = 1'b0, b_aux_req = 1'b0;
  logic       b_cpu_ack, b_aux_ack, b_csn, b_rdn, b_wrn, b_busy;
  logic [7:0] b_cpu_rdata, b_aux_rdata, b_din;
  logic [1:0] b_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ppi_bus_arbiter #(.STROBE_CYCLES(2), .CPU_PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .ppi_addr(ppi_addr), .ppi_din(ppi_din), .ppi_dout(ppi_dout),
    .ppi_csn(ppi_csn), .ppi_rdn(ppi_rdn), .ppi_wrn(ppi_wrn), .busy(busy)
  );

  ppi_bus_arbiter #(.STROBE_CYCLES(1), .CPU_PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(2'd0), .cpu_wdata(8'd0),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .aux_req(b_aux_req), .aux_we(1'b0), .aux_addr(2'd1), .aux_wdata(8'd0),
    .aux_ack(b_aux_ack), .aux_rdata(b_aux_rdata),
    .ppi_addr(b_addr), .ppi_din(b_din), .ppi_dout(ppi_dout),
    .ppi_csn(b_csn), .ppi_rdn(b_rdn), .ppi_wrn(b_wrn), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({ppi_csn, ppi_rdn, ppi_wrn} !== 3'b111) begin errors++; $display("FAIL rst_strobes got %b exp 111", {ppi_csn, ppi_rdn, ppi_wrn}); end
    checks++; if (ppi_addr !== 2'd0 || ppi_din !== 8'd0) begin errors++; $display("FAIL rst_bus addr=%h din=%h exp 0/00", ppi_addr, ppi_din); end
    checks++; if (cpu_ack !== 1'b0 || aux_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b%b exp 00", cpu_ack, aux_ack); end
    checks++; if (cpu_rdata !== 8'd0 || aux_rdata !== 8'd0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 00/00", cpu_rdata, aux_rdata); end
    checks++; if (busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b/%b exp 0/0", busy, b_busy); end
    step(); step();
    rst = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0 || ppi_csn !== 1'b1) begin errors++; $display("FAIL idle_no_req busy=%b csn=%b exp 0/1", busy, ppi_csn); end
  endtask

  // cpu read, addr 1, S=2: csn low 1-4, rdn low 2-3, ack at 5.
  task automatic test_cpu_read();
    logic e_csn, e_rdn, e_ack, e_busy;
    cpu_we = 1'b0; cpu_addr = 2'd1; ppi_dout = 8'hA5; cpu_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      e_csn = !(k >= 1 && k <= 4); e_rdn = !(k == 2 || k == 3);
      e_ack = (k == 5); e_busy = (k <= 5);
      checks++; if (ppi_csn !== e_csn) begin errors++; $display("FAIL rd_csn k=%0d got %b exp %b", k, ppi_csn, e_csn); end
      checks++; if (ppi_rdn !== e_rdn || ppi_wrn !== 1'b1) begin errors++; $display("FAIL rd_strobe k=%0d rdn=%b wrn=%b exp %b/1", k, ppi_rdn, ppi_wrn, e_rdn); end
      checks++; if (cpu_ack !== e_ack || aux_ack !== 1'b0) begin errors++; $display("FAIL rd_ack k=%0d got %b%b exp %b0", k, cpu_ack, aux_ack, e_ack); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rd_busy k=%0d got %b exp %b", k, busy, e_busy); end
      if (k <= 4) begin
        checks++; if (ppi_addr !== 2'd1) begin errors++; $display("FAIL rd_addr k=%0d got %0d exp 1", k, ppi_addr); end
      end
      if (k == 5) begin
        checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data got %h exp a5", cpu_rdata); end
        cpu_req = 1'b0;
      end
    end
  endtask

  // aux write addr 3 data 80: wrn low 2-3, bus stable 1-4, aux_rdata untouched.
  task automatic test_aux_write();
    logic e_csn, e_wrn, e_ack;
    aux_we = 1'b1; aux_addr = 2'd3; aux_wdata = 8'h80; ppi_dout = 8'h3C; aux_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      e_csn = !(k >= 1 && k <= 4); e_wrn = !(k == 2 || k == 3); e_ack = (k == 5);
      checks++; if (ppi_csn !== e_csn) begin errors++; $display("FAIL wr_csn k=%0d got %b exp %b", k, ppi_csn, e_csn); end
      checks++; if (ppi_wrn !== e_wrn || ppi_rdn !== 1'b1) begin errors++; $display("FAIL wr_strobe k=%0d wrn=%b rdn=%b exp %b/1", k, ppi_wrn, ppi_rdn, e_wrn); end
      checks++; if (aux_ack !== e_ack || cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack k=%0d got aux=%b cpu=%b exp %b/0", k, aux_ack, cpu_ack, e_ack); end
      if (k <= 4) begin
        checks++; if (ppi_addr !== 2'd3 || ppi_din !== 8'h80) begin errors++; $display("FAIL wr_bus k=%0d addr=%0d din=%h exp 3/80", k, ppi_addr, ppi_din); end
      end
      if (k == 5) begin
        checks++; if (aux_rdata !== 8'h00 || cpu_rdata !== 8'hA5) begin errors++; $display("FAIL wr_rdata aux=%h cpu=%h exp 00/a5", aux_rdata, cpu_rdata); end
        aux_req = 1'b0;
      end
    end
    checks++; if (ppi_addr !== 2'd3 || ppi_din !== 8'h80) begin errors++; $display("FAIL wr_bus_keep addr=%0d din=%h exp 3/80", ppi_addr, ppi_din); end
  endtask

  // Both held from reset, round-robin: cpu, aux, cpu, aux, cpu with acks every 6 cycles.
  task automatic test_round_robin();
    int n = 0;
    logic e_cpu;
    do_reset();
    cpu_we = 1'b0; aux_we = 1'b0; ppi_dout = 8'h11;
    cpu_req = 1'b1; aux_req = 1'b1;
    for (int cyc = 1; cyc <= 29; cyc++) begin
      step();
      checks++; if (cpu_ack === 1'b1 && aux_ack === 1'b1) begin errors++; $display("FAIL rr_dual_ack cyc=%0d got 11 exp one-hot", cyc); end
      if (cpu_ack === 1'b1 || aux_ack === 1'b1) begin
        e_cpu = ((n % 2) == 0);
        checks++; if (cyc != 5 + 6 * n || cpu_ack !== e_cpu) begin errors++; $display("FAIL rr_grant n=%0d cyc=%0d cpu_ack=%b exp cyc=%0d cpu_ack=%b", n, cyc, cpu_ack, 5 + 6 * n, e_cpu); end
        n++;
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL rr_count got %0d exp 5", n); end
    cpu_req = 1'b0; aux_req = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_settle busy=%b exp 0", busy); end
  endtask

  // dut1, cpu priority, both held: cpu acked at 4, 9, 14, 19; aux never.
  task automatic test_priority();
    logic e_ack;
    do_reset();
    b_cpu_req = 1'b1; b_aux_req = 1'b1;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      step();
      e_ack = ((cyc % 5) == 4);
      checks++; if (b_cpu_ack !== e_ack || b_aux_ack !== 1'b0) begin errors++; $display("FAIL prio cyc=%0d cpu=%b aux=%b exp %b/0", cyc, b_cpu_ack, b_aux_ack, e_ack); end
    end
    b_cpu_req = 1'b0; b_aux_req = 1'b0;
    step(); step();
  endtask

  // dut1, S=1, cpu_req held: first ack at cycle 4, then every 4+S = 5 cycles.
  task automatic test_back_to_back();
    int n = 0;
    int last = 0;
    b_cpu_req = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      step();
      if (b_cpu_ack === 1'b1) begin
        checks++; if ((n == 0 && cyc != 4) || (n > 0 && cyc - last != 5)) begin errors++; $display("FAIL b2b_spacing n=%0d cyc=%0d prev=%0d exp gap 5 (first at 4)", n, cyc, last); end
        last = cyc;
        n++;
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", n); end
    b_cpu_req = 1'b0;
    step(); step();
  endtask

  // Reset during STROBE of a write: outputs return at once, no ack, next read is clean.
  task automatic test_reset_mid_write();
    cpu_we = 1'b1; cpu_addr = 2'd2; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    step(); step();
    checks++; if (ppi_wrn !== 1'b0 || ppi_csn !== 1'b0) begin errors++; $display("FAIL mid_pre wrn=%b csn=%b exp 0/0", ppi_wrn, ppi_csn); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({ppi_csn, ppi_rdn, ppi_wrn} !== 3'b111 || busy !== 1'b0) begin errors++; $display("FAIL mid_async strobes=%b busy=%b exp 111/0", {ppi_csn, ppi_rdn, ppi_wrn}, busy); end
    checks++; if (ppi_addr !== 2'd0 || ppi_din !== 8'd0) begin errors++; $display("FAIL mid_bus addr=%0d din=%h exp 0/00", ppi_addr, ppi_din); end
    cpu_req = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_noack k=%0d ack=%b busy=%b exp 0/0", k, cpu_ack, busy); end
    end
    cpu_we = 1'b0; cpu_addr = 2'd0; ppi_dout = 8'h5A; cpu_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (cpu_ack !== (k == 5)) begin errors++; $display("FAIL mid_next_ack k=%0d got %b exp %b", k, cpu_ack, (k == 5)); end
      if (k == 2) begin
        checks++; if (ppi_rdn !== 1'b0 || ppi_wrn !== 1'b1) begin errors++; $display("FAIL mid_next_rd rdn=%b wrn=%b exp 0/1", ppi_rdn, ppi_wrn); end
      end
      if (k == 5) begin
        checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL mid_next_data got %h exp 5a", cpu_rdata); end
        cpu_req = 1'b0;
      end
    end
    step();
  endtask

  // cpu_req dropped in SETUP with fields changed: latched read completes, no regrant.
  task automatic test_drop_req();
    cpu_we = 1'b0; cpu_addr = 2'd1; ppi_dout = 8'hC3; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0; cpu_addr = 2'd0; cpu_we = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step();
      if (k <= 3) begin
        checks++; if (ppi_rdn !== 1'b0 || ppi_wrn !== 1'b1 || ppi_addr !== 2'd1) begin errors++; $display("FAIL drop_strobe k=%0d rdn=%b wrn=%b addr=%0d exp 0/1/1", k, ppi_rdn, ppi_wrn, ppi_addr); end
      end
      checks++; if (cpu_ack !== (k == 5)) begin errors++; $display("FAIL drop_ack k=%0d got %b exp %b", k, cpu_ack, (k == 5)); end
    end
    checks++; if (cpu_rdata !== 8'hC3) begin errors++; $display("FAIL drop_data got %h exp c3", cpu_rdata); end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_nogrant k=%0d ack=%b busy=%b exp 0/0", k, cpu_ack, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_aux_write();
    test_round_robin();
    test_priority();
    test_back_to_back();
    test_reset_mid_write();
    test_drop_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
